pulse_frame_reader: RTL and testbench

//  Downstream consumer of the neutron pulse-accumulation BRAM. On start it sweeps every

---
 rtl/pulse_frame_reader.sv | 190 +++++++++++++++++++
 tb/tb_pulse_frame_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_frame_reader.sv
// Sweeps the pulse-accumulation BRAM once per start, converts each fp32 word to signed
// fixed point and streams it out on a valid/ready port, optionally clearing each word.
module pulse_frame_reader #(
  parameter int unsigned DEPTH         = 2048,
  parameter int unsigned OUT_W         = 16,
  parameter int unsigned FRAC_BITS     = 12,
  parameter bit          CLEAR_ON_READ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [31:0]      bram_addr,
  output logic [31:0]      bram_data_in,
  output logic             ena,
  output logic             bram_we,
  input  logic [31:0]      bram_data_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic [15:0]      sat_count
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MagW = OUT_W + 25;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
  localparam logic [MagW-1:0] PosMax  = MagW'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic [MagW-1:0] NegMax  = MagW'(64'd1 << (OUT_W - 1));

  typedef enum logic [2:0] {StIdle, StRd, StWait, StCap, StOut, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d, idx_nxt;
  logic              busy_q, busy_d, done_q, done_d;
  logic              ena_q, ena_d, we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [OUT_W-1:0]  m_data_q, m_data_d;
  logic [15:0]       sat_q, sat_d;

  logic               conv_sign;
  logic [7:0]         conv_exp;
  logic [22:0]        conv_frac;
  logic signed [10:0] conv_sh;
  logic [MagW-1:0]    conv_mag;
  logic [OUT_W-1:0]   conv_val;
  logic               conv_sat;

  // fp32 -> signed fixed point; right shifts past the mantissa fall out to 0.
  always_comb begin
    conv_sign = bram_data_out[31];
    conv_exp  = bram_data_out[30:23];
    conv_frac = bram_data_out[22:0];
    conv_sh   = $signed(11'(conv_exp)) - 11'sd150 + $signed(11'(FRAC_BITS));
    conv_mag  = '0;
    conv_val  = '0;
    conv_sat  = 1'b0;
    if (conv_exp == 8'hFF) begin
      conv_sat = 1'b1;
      if (conv_frac == '0) begin
        conv_val = conv_sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end else if (conv_exp != 8'd0) begin
      if (conv_sh[10]) begin
        conv_mag = MagW'({1'b1, conv_frac}) >> (-conv_sh);
      end else if (conv_sh > $signed(11'(OUT_W))) begin
        conv_mag = '1;
      end else begin
        conv_mag = MagW'({1'b1, conv_frac}) << conv_sh;
      end
      if (!conv_sign) begin
        if (conv_mag > PosMax) begin
          conv_sat = 1'b1;
          conv_val = PosMax[OUT_W-1:0];
        end else begin
          conv_val = conv_mag[OUT_W-1:0];
        end
      end else if (conv_mag > NegMax) begin
        conv_sat = 1'b1;
        conv_val = NegMax[OUT_W-1:0];
      end else begin
        conv_val = {OUT_W{1'b0}} - conv_mag[OUT_W-1:0];
      end
    end
  end

  assign idx_nxt = idx_q + IdxW'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ena_d     = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    sat_d     = sat_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          sat_d   = '0;
          busy_d  = 1'b1;
          ena_d   = 1'b1;
          addr_d  = '0;
          state_d = StRd;
        end
      end
      StRd:   state_d = StWait;
      StWait: begin
        ena_d   = CLEAR_ON_READ;
        we_d    = CLEAR_ON_READ;
        state_d = StCap;
      end
      StCap: begin
        m_data_d  = conv_val;
        m_valid_d = 1'b1;
        m_last_d  = (idx_q == LastIdx);
        if (conv_sat && sat_q != 16'hFFFF) sat_d = sat_q + 16'd1;
        state_d = StOut;
      end
      StOut: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (m_last_q) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            idx_d   = idx_nxt;
            addr_d  = 32'(idx_nxt) << 2;
            ena_d   = 1'b1;
            state_d = StRd;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ena_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      sat_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ena_q     <= ena_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      sat_q     <= sat_d;
    end
  end

  // Gate the BRAM strobes so a reset landing in the clear cycle never writes.
  assign ena          = ena_q & ~rst;
  assign bram_we      = we_q & ~rst;
  assign bram_addr    = addr_q;
  assign bram_data_in = 32'h0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;
  assign sat_count    = sat_q;

endmodule

// File: tb/tb_pulse_frame_reader.sv
// Directed bench for pulse_frame_reader at DEPTH=8: conversion table, clear-on-read,
// back-pressure, mid-sweep reset and start-while-busy.
module tb_pulse_frame_reader;
  localparam int Depth = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, m_ready;
  logic        busy, done, ena, bram_we, m_valid, m_last;
  logic [31:0] bram_addr, bram_data_in, bram_data_out;
  logic [15:0] m_data, sat_count;

  logic        start_nc, m_ready_nc;
  logic        busy_nc, done_nc, ena_nc, we_nc, m_valid_nc, m_last_nc;
  logic [31:0] addr_nc, din_nc, dout_nc;
  logic [15:0] m_data_nc, sat_nc;

  pulse_frame_reader #(.DEPTH(Depth)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .bram_addr(bram_addr), .bram_data_in(bram_data_in), .ena(ena), .bram_we(bram_we),
    .bram_data_out(bram_data_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .sat_count(sat_count)
  );

  pulse_frame_reader #(.DEPTH(Depth), .CLEAR_ON_READ(1'b0)) u_dut_nc (
    .clk(clk), .rst(rst), .start(start_nc), .busy(busy_nc), .done(done_nc),
    .bram_addr(addr_nc), .bram_data_in(din_nc), .ena(ena_nc), .bram_we(we_nc),
    .bram_data_out(dout_nc), .m_valid(m_valid_nc), .m_ready(m_ready_nc),
    .m_data(m_data_nc), .m_last(m_last_nc), .sat_count(sat_nc)
  );

  // BRAM models, 1-cycle read latency, bulk-loadable from the stimulus.
  logic [31:0] mem [Depth];
  logic [31:0] mem_nc [Depth];
  logic [31:0] load_buf [Depth];
  logic        load_en = 1'b0, load_en_nc = 1'b0;
  int          done_cnt = 0, we_nc_seen = 0, rst_wr = 0;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < Depth; i++) mem[i] <= load_buf[i];
    end else if (ena) begin
      if (bram_we) mem[bram_addr[4:2]] <= bram_data_in;
      else bram_data_out <= mem[bram_addr[4:2]];
    end
    if (done) done_cnt <= done_cnt + 1;
    if (rst && bram_we) rst_wr <= rst_wr + 1;
  end

  always @(posedge clk) begin
    if (load_en_nc) begin
      for (int i = 0; i < Depth; i++) mem_nc[i] <= load_buf[i];
    end else if (ena_nc) begin
      if (we_nc) mem_nc[addr_nc[4:2]] <= din_nc;
      else dout_nc <= mem_nc[addr_nc[4:2]];
    end
    if (we_nc) we_nc_seen <= we_nc_seen + 1;
  end

  typedef struct {
    logic [31:0] word;
    logic [15:0] exp;
    logic        sat;
  } vec_t;
  vec_t vecs [24];

  int checks = 0, passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic load(input int base, input bit nc);
    for (int i = 0; i < Depth; i++) load_buf[i] = vecs[base + i].word;
    if (nc) load_en_nc = 1'b1; else load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    load_en_nc = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full frame with m_ready held high; optionally re-pulse start mid-frame.
  task automatic run_frame(input int base, input int restart_at, input logic [15:0] exp_sat);
    int n, rd_k, cyc, d0;
    load(base, 1'b0);
    m_ready = 1'b1;
    d0 = done_cnt;
    pulse_start();
    check("busy_after_start", busy, 1);
    n = 0; rd_k = 0; cyc = 0;
    while (n < Depth && cyc < 300) begin
      start = (cyc == restart_at);
      if (ena && !bram_we) begin
        check("read_addr", bram_addr, rd_k * 4);
        rd_k++;
      end
      if (m_valid && m_ready) begin
        check("sample", m_data, vecs[base + n].exp);
        check("last_flag", m_last, n == Depth - 1);
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("handshakes", n, Depth);
    check("reads", rd_k, Depth);
    check("done_pulse", done, 1);
    check("sat_count", sat_count, exp_sat);
    @(negedge clk);
    check("done_low", done, 0);
    check("busy_low", busy, 0);
    check("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    int n, cyc, stall, d0;
    logic tog, held_valid;
    logic [15:0] held_data;

    vecs[0]  = '{32'h3F73A29C, 16'h0F3A, 1'b0};
    vecs[1]  = '{32'hBF000000, 16'hF800, 1'b0};
    for (int i = 2; i < 8; i++) vecs[i] = '{32'h0, 16'h0000, 1'b0};
    vecs[8]  = '{32'h3F800000, 16'h1000, 1'b0};
    vecs[9]  = '{32'h00400000, 16'h0000, 1'b0};
    vecs[10] = '{32'h3A000000, 16'h0002, 1'b0};
    vecs[11] = '{32'h42C80000, 16'h7FFF, 1'b1};
    vecs[12] = '{32'hC2C80000, 16'h8000, 1'b1};
    vecs[13] = '{32'h7FC00000, 16'h0000, 1'b1};
    vecs[14] = '{32'hC1000000, 16'h8000, 1'b0};
    vecs[15] = '{32'h40FFFE00, 16'h7FFF, 1'b0};
    vecs[16] = '{32'h7F800000, 16'h7FFF, 1'b1};
    vecs[17] = '{32'hFF800000, 16'h8000, 1'b1};
    vecs[18] = '{32'h41000000, 16'h7FFF, 1'b1};
    vecs[19] = '{32'h3F000001, 16'h0800, 1'b0};
    vecs[20] = '{32'hBF7FFFFF, 16'hF001, 1'b0};
    vecs[21] = '{32'hFF7FFFFF, 16'h8000, 1'b1};
    vecs[22] = '{32'h39800000, 16'h0001, 1'b0};
    vecs[23] = '{32'h397FFFFF, 16'h0000, 1'b0};

    rst = 1'b1; start = 1'b0; start_nc = 1'b0; m_ready = 1'b0; m_ready_nc = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", m_valid, 0);
    check("rst_ena", ena, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_data", m_data, 0);
    check("rst_sat", sat_count, 0);

    // Basic frame, then clear-on-read leaves every word zero.
    run_frame(0, -1, 16'd0);
    for (int i = 0; i < Depth; i++) check("cleared_word", mem[i], 0);

    // Saturation, NaN, denormal and exact-minimum conversions.
    run_frame(8, -1, 16'd3);

    // Read-only instance leaves contents intact and never writes.
    load(0, 1'b1);
    start_nc = 1'b1;
    @(negedge clk);
    start_nc = 1'b0;
    cyc = 0;
    while (!done_nc && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("nc_done", done_nc, 1);
    check("nc_no_write", we_nc_seen, 0);
    for (int i = 0; i < Depth; i++) check("nc_word", mem_nc[i], vecs[i].word);

    // Toggling m_ready plus a 20-cycle stall on word 2.
    load(8, 1'b0);
    d0 = done_cnt;
    pulse_start();
    n = 0; cyc = 0; stall = 0; tog = 1'b0; held_valid = 1'b0; held_data = '0;
    while (n < Depth && cyc < 500) begin
      if (held_valid) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, held_data);
      end
      tog = ~tog;
      if (m_valid && n == 2 && stall < 20) begin
        m_ready = 1'b0;
        stall++;
      end else begin
        m_ready = tog;
      end
      held_valid = m_valid && !m_ready;
      held_data  = m_data;
      if (m_valid && m_ready) begin
        check("bp_sample", m_data, vecs[8 + n].exp);
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    check("bp_handshakes", n, Depth);
    check("bp_stall_len", stall, 20);
    check("bp_done", done, 1);
    check("bp_sat", sat_count, 3);
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_done_once", done_cnt - d0, 1);

    // Reset while word 4 sits in the output stage.
    load(8, 1'b0);
    d0 = done_cnt;
    pulse_start();
    n = 0; cyc = 0;
    while (!(m_valid && n == 4) && cyc < 200) begin
      if (m_valid && m_ready) n++;
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_word4", n, 4);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_last", m_last, 0);
    check("mid_rst_sat", sat_count, 0);
    check("mid_rst_ena", ena, 0);
    check("mid_rst_addr", bram_addr, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_no_write", rst_wr, 0);
    run_frame(16, -1, 16'd4);

    // start re-pulsed mid-frame is ignored.
    d0 = done_cnt;
    run_frame(0, 5, 16'd0);
    repeat (10) @(negedge clk);
    check("restart_idle", busy, 0);
    check("restart_one_done", done_cnt - d0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
